// File: rtl/wb_stage_if.sv
// Writeback stage bus: M-stage inputs plus the register-file write port and retire count.
interface wb_stage_if;
    logic        en;
    logic        clr;
    logic        M_valid;
    logic [31:0] M_PC;
    logic        M_Wr;
    logic [4:0]  M_A3;
    logic [1:0]  M_WSel;
    logic [2:0]  M_LdType;
    logic [31:0] M_ALURes;
    logic [31:0] M_MemRD;
    logic        Wr;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] PC4;
    logic [31:0] retire_cnt;

    modport slave (
        input  en, clr, M_valid, M_PC, M_Wr, M_A3, M_WSel, M_LdType, M_ALURes, M_MemRD,
        output Wr, A3, WD, PC4, retire_cnt
    );

    modport master (
        output en, clr, M_valid, M_PC, M_Wr, M_A3, M_WSel, M_LdType, M_ALURes, M_MemRD,
        input  Wr, A3, WD, PC4, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// P5 writeback stage: load extraction, writeback mux, GRF write port and retire counter.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN; otherwise retire_cnt is 0.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   bus
);
    localparam int unsigned XLEN = 32;

    // Named PC4 so the register file's trace can reach it as W.PC4.
    logic [XLEN-1:0] PC4;
    logic            wr_q;
    logic [4:0]      a3_q;
    logic [XLEN-1:0] wd_q;

    logic [1:0]      off_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;
    logic [XLEN-1:0] ld_c;
    logic [XLEN-1:0] wd_c;
    logic            wr_c;

    // Load extraction and writeback source select
    always_comb begin
        off_c  = bus.M_ALURes[1:0];
        byte_c = bus.M_MemRD[{off_c, 3'b000} +: 8];
        half_c = off_c[1] ? bus.M_MemRD[31:16] : bus.M_MemRD[15:0];
        ld_c   = bus.M_MemRD;
        wd_c   = bus.M_ALURes;
        wr_c   = bus.M_valid & bus.M_Wr & (bus.M_A3 != 5'd0);
        case (bus.M_LdType)
            3'b001:  ld_c = {24'h0, byte_c};
            3'b010:  ld_c = {{24{byte_c[7]}}, byte_c};
            3'b011:  ld_c = {16'h0, half_c};
            3'b100:  ld_c = {{16{half_c[15]}}, half_c};
            default: ld_c = bus.M_MemRD;
        endcase
        case (bus.M_WSel)
            2'b10:   wd_c = bus.M_PC + XLEN'(8);
            2'b01:   wd_c = ld_c;
            default: wd_c = bus.M_ALURes;
        endcase
    end

    // Pipeline register: reset and flush both leave a bubble
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            wr_q <= 1'b0;
            a3_q <= 5'd0;
            wd_q <= '0;
            PC4  <= RESET_PC + XLEN'(4);
        end else if (bus.en) begin
            wr_q <= wr_c;
            a3_q <= bus.M_A3;
            wd_q <= wd_c;
            PC4  <= bus.M_PC + XLEN'(4);
        end
    end

    assign bus.Wr  = wr_q;
    assign bus.A3  = a3_q;
    assign bus.WD  = wd_q;
    assign bus.PC4 = PC4;

`ifdef WB_RETIRE_CNT_EN
    logic [XLEN-1:0] cnt_q;

    // Counts valid instructions captured into W; wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!bus.clr && bus.en && bus.M_valid) begin
            cnt_q <= cnt_q + XLEN'(1);
        end
    end

    assign bus.retire_cnt = cnt_q;
`else
    assign bus.retire_cnt = 32'h0;
`endif
endmodule
